// File: rtl/ofm_pkg.sv
// Shared definitions for the OFM writeback path: lane geometry, packed word type, lane indices.
package ofm_pkg;

  localparam int OFM_DATA_W = 8;
  localparam int OFM_LANES  = 4;

  typedef logic [OFM_LANES-1:0][OFM_DATA_W-1:0] ofm_word_t;

  localparam int LANE_0 = 0;
  localparam int LANE_1 = 1;
  localparam int LANE_2 = 2;
  localparam int LANE_3 = 3;

endpackage

// File: rtl/ofm_word_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on pop_data whenever not empty.
module ofm_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          drop
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push into a full FIFO still lands when the head leaves at the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!clr && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofm_quad_collector.sv
// Collects one byte per PE lane, packs a complete group of four into a word and queues it.
module ofm_quad_collector
  import ofm_pkg::*;
#(
  parameter int DATA_W = OFM_DATA_W,
  parameter int LANES  = OFM_LANES,
  parameter int DEPTH  = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    soft_clr,
  input  logic [DATA_W-1:0]       OFM_0,
  input  logic [DATA_W-1:0]       OFM_1,
  input  logic [DATA_W-1:0]       OFM_2,
  input  logic [DATA_W-1:0]       OFM_3,
  input  logic [LANES-1:0]        valid,
  output logic [LANES*DATA_W-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES-1:0]        lane_pending,
  output logic [CW-1:0]           word_count,
  output logic                    err_lane_ovf,
  output logic                    err_fifo_ovf
);

  // Output handshake: a word transfers on any edge where m_valid && m_ready;
  // m_valid never depends on m_ready and m_data holds steady until the transfer.

  logic                               rst;
  logic [LANES-1:0][DATA_W-1:0]       lane_in;
  logic [LANES-1:0][DATA_W-1:0]       hold;
  logic [LANES-1:0][DATA_W-1:0]       word;
  logic [LANES-1:0]                   cap;
  logic [LANES-1:0]                   nxt;
  logic                               word_done;
  logic                               lane_ovf;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               fifo_drop;

  assign rst = reset_n | soft_clr;

  assign lane_in[LANE_0] = OFM_0;
  assign lane_in[LANE_1] = OFM_1;
  assign lane_in[LANE_2] = OFM_2;
  assign lane_in[LANE_3] = OFM_3;

  assign cap       = valid & ~lane_pending;
  assign nxt       = lane_pending | cap;
  assign word_done = &nxt;
  assign lane_ovf  = |(valid & lane_pending);

  // Lanes arriving on the completing edge bypass the holding registers into the word.
  always_comb begin
    word = hold;
    for (int i = 0; i < LANES; i++) begin
      if (cap[i]) word[i] = lane_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold         <= '0;
      lane_pending <= '0;
      err_lane_ovf <= 1'b0;
      err_fifo_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (cap[i]) hold[i] <= lane_in[i];
      end
      lane_pending <= word_done ? '0 : nxt;
      if (lane_ovf)  err_lane_ovf <= 1'b1;
      if (fifo_drop) err_fifo_ovf <= 1'b1;
    end
  end

  ofm_word_fifo #(
    .W     (LANES*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (rst),
    .push      (word_done),
    .push_data (word),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (word_count),
    .drop      (fifo_drop)
  );

  assign m_valid = ~fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/ofm_quad_collector.md
Name: ofm_quad_collector

Overview:
- Sits directly downstream of the four-PE cluster.
- Each cluster PE (lanes 0..3) emits one 8-bit OFM byte with a one-cycle valid pulse. Lanes complete independently, in any order.
- This block holds the lane bytes until all four lanes of a group have arrived, then packs them into one 32-bit word.
- Completed words go into a small FIFO that drains through a ready/valid port toward the OFM writeback path. The cluster cannot stall, so overruns are flagged, never back-pressured.

Parameters:
- DATA_W, 8, width of one OFM lane byte.
- LANES, 4, number of PE lanes packed per word (fixed at 4 for this revision).
- DEPTH, 8, FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset. Synchronous, active-high: asserted when 1. The name is kept for codebase consistency.
- soft_clr  in  1  synchronous clear. Same effect as reset.
- OFM_0  in  DATA_W  lane 0 byte.
- OFM_1  in  DATA_W  lane 1 byte.
- OFM_2  in  DATA_W  lane 2 byte.
- OFM_3  in  DATA_W  lane 3 byte.
- valid  in  LANES  per-lane byte strobe; bit i qualifies OFM_i.
- m_data  out  LANES*DATA_W  packed word, {lane3,lane2,lane1,lane0}.
- m_valid  out  1  FIFO head is valid.
- m_ready  in  1  consumer accepts the head.
- lane_pending  out  LANES  lanes already captured for the current word.
- word_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err_lane_ovf  out  1  sticky: a lane byte was dropped.
- err_fifo_ovf  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset and clear:
  - reset_n=1 or soft_clr=1 at a clock edge clears everything: holding registers, lane_pending, FIFO pointers, word_count, m_valid, m_data, both error flags.
  - Reset/clear has priority over all other activity, including mid-word and mid-drain.
- Lane capture:
  - At an edge with valid[i]=1 and lane_pending[i]=0: OFM_i is written to hold[i] and lane_pending[i] is set.
- Lane overrun:
  - valid[i]=1 with lane_pending[i]=1 is an overrun.
  - The incoming byte is dropped, hold[i] is unchanged and err_lane_ovf is set.
  - This applies even in the same cycle the word completes.
- Completion:
  - Let nxt = lane_pending | (valid & ~lane_pending). If nxt is all ones, the word completes this edge.
  - The packed word takes each lane from the incoming OFM_i if it was captured this edge, otherwise from hold[i].
  - The word is pushed into the FIFO and lane_pending clears to 0 at the same edge.
  - If all four valid bits arrive together with lane_pending=0, the word completes in that single cycle.
- Latency:
  - A completing edge writes the FIFO.
  - When the FIFO was empty, m_valid rises after that edge: one cycle from the last lane strobe to m_valid.
  - There is no combinational bypass.
- FIFO:
  - Show-ahead: m_data always shows the head word while m_valid=1.
  - A pop occurs at an edge with m_valid & m_ready.
  - A push while full is accepted only if a pop happens at the same edge; word_count is then unchanged.
  - A push while full with no pop drops the word and sets err_fifo_ovf. Lane_pending still clears.
  - Simultaneous push and pop when not full leaves word_count unchanged.
  - Pointers wrap modulo DEPTH.
- Idle output:
  - m_valid=0 when word_count=0.
  - m_data is don't-care when m_valid=0, but it resets to 0.
- Error flags:
  - Both stay set until reset or soft_clr.
  - Neither flag alters the data path beyond the drop described above.

Decomposition:
- Shared package ofm_pkg:
  - OFM_DATA_W=8 and OFM_LANES=4.
  - typedef ofm_word_t (packed LANES x DATA_W).
  - Lane index constants.
- One sub-module, ofm_word_fifo:
  - Parameterised synchronous show-ahead FIFO.
  - Provides push, pop, full, empty and count.
  - Reused by other writeback stages.

Test Plan:
- In-order lanes: valid=0001,0010,0100,1000 on consecutive cycles with bytes 0x11,0x22,0x33,0x44 -> one cycle after the 4th strobe, m_valid=1 and m_data=0x44332211; word_count=1.
- Simultaneous lanes and backpressure: valid=1111 with bytes A0,A1,A2,A3 for 3 cycles while m_ready=0 -> word_count=3, then m_ready=1 drains 0xA3A2A1A0 three times in order; lane_pending stays 0000.
- Lane overrun: valid=0001 (0x05), then valid=0001 (0x06), then valid=1110 (0x07,0x08,0x09) -> err_lane_ovf=1, word=0x09080705.
- FIFO overflow: with m_ready=0, complete DEPTH+1 words (values 1..9 replicated per lane) -> word_count=8, err_fifo_ovf=1, and draining returns words 1..8. Repeat with m_ready=1 on the 9th push -> no error.
- Clear mid-operation: lane_pending=0101 and word_count=3, pulse soft_clr -> next cycle all outputs are 0. Then a full valid=1111 word appears alone at the FIFO head.
- Reset during drain: assert reset_n=1 while m_valid=1 and m_ready=1 -> next cycle m_valid=0, word_count=0 and both error flags are 0.
